// File: rtl/memory_stage_if.sv
// memory_stage_if: req/valid data-memory port between the memory stage and the memory
interface memory_stage_if #(parameter int DATA_W = 16);
  logic              mem_en;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_valid);
  modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_valid);
endinterface

// File: rtl/memory_stage.sv
// memory_stage: X/M register, variable-latency data-memory access FSM and M/W register
module memory_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_out_x,
  input  logic [DATA_W-1:0] store_data_x,
  input  logic [REG_W-1:0]  dst_reg_x,
  input  logic [REG_W-1:0]  rt_x,
  input  logic [REG_W-1:0]  rd_x,
  input  logic              reg_write_x,
  input  logic              mem_read_x,
  input  logic              mem_write_x,
  input  logic              flush_xm,
  input  logic              b_m2m,
  input  logic [DATA_W-1:0] writeback_data,
  output logic [DATA_W-1:0] alu_out_xm,
  output logic [REG_W-1:0]  dst_reg_xm,
  output logic [REG_W-1:0]  rt_xm,
  output logic [REG_W-1:0]  rd_xm,
  output logic              reg_write_xm,
  output logic              mem_write_xm,
  output logic              stall_m,
  output logic              mem_err,
  output logic [DATA_W-1:0] wb_data_mw,
  output logic [REG_W-1:0]  dst_reg_mw,
  output logic              reg_write_mw,
  memory_stage_if.master    mem
);
  localparam int CW = $clog2(TMO_CYC);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } xm_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dst;
    logic              rw;
  } mw_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  xm_t           xm_q, xm_d;
  mw_t           mw_q, mw_d;
  logic          access, tmo, done;
  // access handshake: stall until mem_valid or the wait budget runs out
  always_comb begin
    access   = xm_q.mr | xm_q.mw;
    tmo      = state_q == S_WAIT && cnt_q == CW'(TMO_CYC - 1) && !mem.mem_valid;
    done     = mem.mem_valid | tmo;
    stall_m  = access & ~done;
    state_d  = stall_m ? S_WAIT : S_IDLE;
    cnt_d    = state_q == S_WAIT ? cnt_q + 1'b1 : '0;
    err_d    = err_q | tmo;
  end
  // pipeline registers: X/M holds on stall, M/W takes a bubble on stall
  always_comb begin
    xm_d = stall_m ? xm_q : flush_xm ? '0 :
           '{alu_out_x, store_data_x, dst_reg_x, rt_x, rd_x, reg_write_x, mem_read_x, mem_write_x};
    mw_d = stall_m ? '{mw_q.data, mw_q.dst, 1'b0} :
           '{xm_q.mr ? (tmo ? '0 : mem.mem_rdata) : xm_q.alu, xm_q.dst, xm_q.rw};
  end
  // state and pipeline flops; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      xm_q    <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      xm_q    <= xm_d;
      mw_q    <= mw_d;
    end
  end
  assign mem.mem_en    = access;
  assign mem.mem_wr    = xm_q.mw;
  assign mem.mem_addr  = xm_q.alu;
  assign mem.mem_wdata = b_m2m ? writeback_data : xm_q.sd;
  assign alu_out_xm    = xm_q.alu;
  assign dst_reg_xm    = xm_q.dst;
  assign rt_xm         = xm_q.rt;
  assign rd_xm         = xm_q.rd;
  assign reg_write_xm  = xm_q.rw;
  assign mem_write_xm  = xm_q.mw;
  assign mem_err       = err_q;
  assign wb_data_mw    = mw_q.data;
  assign dst_reg_mw    = mw_q.dst;
  assign reg_write_mw  = mw_q.rw;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized + directed check of memory_stage against an instruction-level model
module tb_memory_stage;
  localparam int DW = 16, RW = 4, TMO = 8;
  logic clk = 0, rst = 1;
  logic [DW-1:0] alu_out_x = 0, store_data_x = 0, writeback_data = 0;
  logic [RW-1:0] dst_reg_x = 0, rt_x = 0, rd_x = 0;
  logic reg_write_x = 0, mem_read_x = 0, mem_write_x = 0, flush_xm = 0, b_m2m = 0;
  logic [DW-1:0] alu_out_xm, wb_data_mw;
  logic [RW-1:0] dst_reg_xm, rt_xm, rd_xm, dst_reg_mw;
  logic reg_write_xm, mem_write_xm, stall_m, mem_err, reg_write_mw;
  memory_stage_if #(.DATA_W(DW)) mif();
  memory_stage #(.DATA_W(DW), .REG_W(RW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .alu_out_x(alu_out_x), .store_data_x(store_data_x),
    .dst_reg_x(dst_reg_x), .rt_x(rt_x), .rd_x(rd_x), .reg_write_x(reg_write_x),
    .mem_read_x(mem_read_x), .mem_write_x(mem_write_x), .flush_xm(flush_xm), .b_m2m(b_m2m),
    .writeback_data(writeback_data), .alu_out_xm(alu_out_xm), .dst_reg_xm(dst_reg_xm),
    .rt_xm(rt_xm), .rd_xm(rd_xm), .reg_write_xm(reg_write_xm), .mem_write_xm(mem_write_xm),
    .stall_m(stall_m), .mem_err(mem_err), .wb_data_mw(wb_data_mw), .dst_reg_mw(dst_reg_mw),
    .reg_write_mw(reg_write_mw), .mem(mif.master));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // instruction-level model: the instruction sitting in M and how many cycles it has been there
  logic [DW-1:0] m_alu = 0, m_sd = 0, w_data = 0;
  logic [RW-1:0] m_dst = 0, m_rt = 0, m_rd = 0, w_dst = 0;
  logic m_rw = 0, m_mr = 0, m_mw = 0, w_rw = 0, m_err = 0;
  int m_age = 0;
  function automatic bit f_tmo();
    return (m_mr | m_mw) && m_age == TMO && !mif.mem_valid;
  endfunction
  function automatic bit f_stall();
    return (m_mr | m_mw) && !mif.mem_valid && !f_tmo();
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      {m_alu, m_sd, m_dst, m_rt, m_rd, m_rw, m_mr, m_mw} = '0;
      {w_data, w_dst, w_rw} = '0;
      m_err = 0;
      m_age = 0;
    end else if (f_stall()) begin
      w_rw = 0;
      m_age++;
    end else begin
      w_data = m_mr ? (f_tmo() ? '0 : mif.mem_rdata) : m_alu;
      w_dst  = m_dst;
      w_rw   = m_rw;
      m_err  = m_err | f_tmo();
      m_age  = 0;
      if (flush_xm) {m_alu, m_sd, m_dst, m_rt, m_rd, m_rw, m_mr, m_mw} = '0;
      else {m_alu, m_sd, m_dst, m_rt, m_rd, m_rw, m_mr, m_mw} =
        {alu_out_x, store_data_x, dst_reg_x, rt_x, rd_x, reg_write_x, mem_read_x, mem_write_x};
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_en", mif.mem_en, m_mr | m_mw);
      chk("stall_m", stall_m, f_stall());
      chk("mem_err", mem_err, m_err);
      if (m_mr | m_mw) begin
        chk("mem_wr", mif.mem_wr, m_mw);
        chk("mem_addr", mif.mem_addr, m_alu);
        chk("mem_wdata", mif.mem_wdata, b_m2m ? writeback_data : m_sd);
      end
      chk("xm_fields", {alu_out_xm, dst_reg_xm, rt_xm, rd_xm, reg_write_xm, mem_write_xm},
          {m_alu, m_dst, m_rt, m_rd, m_rw, m_mw});
      chk("mw_fields", {wb_data_mw, dst_reg_mw, reg_write_mw}, {w_data, w_dst, w_rw});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [DW-1:0] alu, sd, input logic [RW-1:0] dst,
                     input logic rw, mr, mw, fl, bm, input logic [DW-1:0] wbd);
    alu_out_x = alu; store_data_x = sd; dst_reg_x = dst; rt_x = dst ^ 4'h5; rd_x = dst ^ 4'hA;
    reg_write_x = rw; mem_read_x = mr; mem_write_x = mw; flush_xm = fl; b_m2m = bm;
    writeback_data = wbd;
  endtask
  initial begin
    int n, pv;
    mif.mem_valid = 0;
    mif.mem_rdata = 0;
    step(); step();
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_out", {mif.mem_en, stall_m, mem_err, reg_write_mw, wb_data_mw}, 0);
    mif.mem_valid = 1;
    drv(16'h1234, 0, 3, 1, 0, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_no_mem_en", mif.mem_en, 0);
    step();
    @(negedge clk);
    chk("alu_wb", {reg_write_mw, dst_reg_mw, wb_data_mw}, {1'b1, 4'd3, 16'h1234});
    mif.mem_valid = 0;
    drv(16'h0040, 0, 5, 1, 1, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("load_stall_addr", {stall_m, mif.mem_addr}, {1'b1, 16'h0040});
      step();
    end
    mif.mem_valid = 1;
    mif.mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("load_done", {stall_m, reg_write_mw}, 0);
    step();
    mif.mem_valid = 0;
    @(negedge clk);
    chk("load_wb", {reg_write_mw, dst_reg_mw, wb_data_mw}, {1'b1, 4'd5, 16'hBEEF});
    mif.mem_valid = 1;
    drv(16'h0080, 16'h1111, 6, 0, 0, 1, 0, 1, 16'hA5A5);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 16'hA5A5);
    @(negedge clk);
    chk("store_m2m", {mif.mem_wr, mif.mem_wdata}, {1'b1, 16'hA5A5});
    step();
    @(negedge clk);
    chk("store_no_wb", reg_write_mw, 0);
    mif.mem_valid = 0;
    drv(16'h0022, 0, 7, 1, 1, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall_m) break;
      n++;
      step();
    end
    chk("tmo_stall_cycles", n, TMO);
    step();
    @(negedge clk);
    chk("tmo_wb", {mem_err, reg_write_mw, dst_reg_mw, wb_data_mw}, {1'b1, 1'b1, 4'd7, 16'h0000});
    drv(16'h0010, 0, 1, 1, 1, 0, 1, 0, 0);
    step();
    @(negedge clk);
    chk("flush_bubble", {mif.mem_en, reg_write_xm}, 0);
    drv(16'h0030, 0, 2, 1, 1, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(); step();
    mif.mem_valid = 1;
    mif.mem_rdata = 16'h5555;
    @(negedge clk);
    chk("flush_in_stall", {reg_write_xm, alu_out_xm}, {1'b1, 16'h0030});
    step();
    mif.mem_valid = 0;
    @(negedge clk);
    chk("flush_stall_wb", {reg_write_mw, wb_data_mw}, {1'b1, 16'h5555});
    drv(16'h0050, 0, 4, 1, 1, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_in_wait", {mif.mem_en, stall_m, mem_err, wb_data_mw, dst_reg_mw, reg_write_mw}, 0);
    pv = 50;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 50 == 0) pv = (c / 50) % 4 == 3 ? 0 : $urandom_range(10, 100);
      rst = $urandom_range(0, 199) == 0;
      drv(DW'($urandom), DW'($urandom), RW'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0), 1'($urandom), DW'($urandom));
      mif.mem_valid = $urandom_range(1, 100) <= pv;
      mif.mem_rdata = DW'($urandom);
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
